// File: rtl/regfile_pkg.sv
// Shared register-file definitions, used by the register file and its write buffer.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;

    // Register 0 is hard-wired; writes to it are discarded.
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    // FIFO occupancy change for one edge, encoded as {push, pop}.
    typedef enum logic [1:0] {
        FifoHold = 2'b00,
        FifoPop  = 2'b01,
        FifoPush = 2'b10,
        FifoBoth = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/regfile_write_buffer_if.sv
// Bus bundle between the writeback stage / decode / register file and the write buffer.
interface regfile_write_buffer_if
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DATA_W = REG_DATA_W
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Writeback request
    logic              In_valid;
    logic              In_ready;
    logic [ADDR_W-1:0] In_addr;
    logic [DATA_W-1:0] In_data;

    // Register file write port
    logic              Wr_grant;
    logic [ADDR_W-1:0] Write_addr;
    logic              Write_En;
    logic [DATA_W-1:0] Write_data;

    // Decode bypass
    logic [ADDR_W-1:0] Read_addr1;
    logic [ADDR_W-1:0] Read_addr2;
    logic              Byp_hit1;
    logic [DATA_W-1:0] Byp_data1;
    logic              Byp_hit2;
    logic [DATA_W-1:0] Byp_data2;

    logic [CNT_W-1:0]  Count;

    // Buffer side
    modport slave (
        input  In_valid, In_addr, In_data, Wr_grant, Read_addr1, Read_addr2,
        output In_ready, Write_addr, Write_En, Write_data,
               Byp_hit1, Byp_data1, Byp_hit2, Byp_data2, Count
    );

    // Surrounding pipeline side
    modport master (
        output In_valid, In_addr, In_data, Wr_grant, Read_addr1, Read_addr2,
        input  In_ready, Write_addr, Write_En, Write_data,
               Byp_hit1, Byp_data1, Byp_hit2, Byp_data2, Count
    );

endinterface

// File: rtl/regfile_write_buffer_bypass_lookup.sv
// Youngest-first match of one read address against the pending write entries.
module wb_bypass_lookup
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DATA_W = REG_DATA_W
) (
    input  logic [DEPTH-1:0]              i_valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0]  i_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  i_data,
    input  logic [$clog2(DEPTH)-1:0]      i_head,
    input  logic [$clog2(DEPTH+1)-1:0]    i_count,
    input  logic [ADDR_W-1:0]             i_read_addr,
    output logic                          o_hit,
    output logic [DATA_W-1:0]             o_data
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic w_zero_addr;

    assign w_zero_addr = (i_read_addr == ADDR_W'(REG_ZERO));

    // Walk oldest to youngest from the head; a later match overrides, so the youngest wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx    = '0;
        o_hit  = 1'b0;
        o_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = i_head + PTR_W'(k);
            if ((CNT_W'(k) < i_count) && i_valid[idx] && !w_zero_addr &&
                (i_addr[idx] == i_read_addr)) begin
                o_hit  = 1'b1;
                o_data = i_data[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_write_buffer.sv
// In-order write queue in front of the register file's single write port, with two
// bypass ports so decode always sees the newest pending value of a register.
module regfile_write_buffer
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DATA_W = REG_DATA_W
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    regfile_write_buffer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // FIFO state
    logic [DEPTH-1:0]             r_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;
    logic [PTR_W-1:0]             r_head;
    logic [PTR_W-1:0]             r_tail;
    logic [CNT_W-1:0]             r_count;

    logic                         w_in_ready;
    logic                         w_accept;
    logic                         w_push;
    logic                         w_pop;
    fifo_op_e                     w_op;

    logic                         w_byp_hit1;
    logic                         w_byp_hit2;
    logic [DATA_W-1:0]            w_byp_data1;
    logic [DATA_W-1:0]            w_byp_data2;

    // Full buffer rejects even while draining: In_ready ignores Wr_grant.
    assign w_in_ready = (r_count != FULL_COUNT);
    assign w_accept   = bus.In_valid && w_in_ready;
    // Writes to register 0 are accepted but never stored.
    assign w_push     = w_accept && (bus.In_addr != ADDR_W'(REG_ZERO));
    assign w_pop      = bus.Wr_grant && (r_count != '0);
    assign w_op       = fifo_op(w_push, w_pop);

    // Pointer, occupancy and valid-bit update; reset overrides any push or pop.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            unique case (w_op)
                FifoPush: r_count <= r_count + 1'b1;
                FifoPop:  r_count <= r_count - 1'b1;
                default:  r_count <= r_count;
            endcase
            // Push and pop never target the same slot: pop needs Count > 0, push needs
            // Count < DEPTH, and head == tail only at empty or full.
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
        end
    end

    // Entry payload; stale slots are masked by r_valid and Count, so no reset needed.
    always_ff @(posedge Clock) begin
        if (Reset_n && w_push) begin
            r_addr[r_tail] <= bus.In_addr;
            r_data[r_tail] <= bus.In_data;
        end
    end

    // Register file write port: head entry while non-empty, zeros otherwise.
    always_comb begin
        bus.Write_En   = w_pop;
        bus.Write_addr = '0;
        bus.Write_data = '0;
        if (r_count != '0) begin
            bus.Write_addr = r_addr[r_head];
            bus.Write_data = r_data[r_head];
        end
    end

    assign bus.In_ready = w_in_ready;
    assign bus.Count    = r_count;

    wb_bypass_lookup #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bypass_lookup1 (
        .i_valid     (r_valid),
        .i_addr      (r_addr),
        .i_data      (r_data),
        .i_head      (r_head),
        .i_count     (r_count),
        .i_read_addr (bus.Read_addr1),
        .o_hit       (w_byp_hit1),
        .o_data      (w_byp_data1)
    );

    wb_bypass_lookup #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bypass_lookup2 (
        .i_valid     (r_valid),
        .i_addr      (r_addr),
        .i_data      (r_data),
        .i_head      (r_head),
        .i_count     (r_count),
        .i_read_addr (bus.Read_addr2),
        .o_hit       (w_byp_hit2),
        .o_data      (w_byp_data2)
    );

    assign bus.Byp_hit1  = w_byp_hit1;
    assign bus.Byp_data1 = w_byp_data1;
    assign bus.Byp_hit2  = w_byp_hit2;
    assign bus.Byp_data2 = w_byp_data2;

endmodule

// File: doc/regfile_write_buffer.md
# regfile_write_buffer

Write-side companion of the 32 x 32-bit register file. It accepts register write requests from the writeback stage and queues them in a DEPTH-entry in-order FIFO. It drives the register file's single write port (Write_addr/Write_En/Write_data) only while the port is granted. Two bypass ports return the newest still-pending value for any read address, so decode never reads stale data while writes are queued.

## Interface
- DEPTH, 4, FIFO entries (power of two, >= 2)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- Clock  in  1  rising-edge clock
- Reset_n  in  1  reset, synchronous and active-low
- In_valid  in  1  write request valid
- In_ready  out  1  buffer can accept a request
- In_addr  in  ADDR_W  destination register
- In_data  in  DATA_W  value to write
- Wr_grant  in  1  register file write port available this cycle
- Write_addr  out  ADDR_W  to register file
- Write_En  out  1  to register file
- Write_data  out  DATA_W  to register file
- Read_addr1  in  ADDR_W  bypass lookup address, port 1
- Read_addr2  in  ADDR_W  bypass lookup address, port 2
- Byp_hit1  out  1  a pending entry matches Read_addr1
- Byp_data1  out  DATA_W  newest pending data for Read_addr1
- Byp_hit2  out  1  a pending entry matches Read_addr2
- Byp_data2  out  DATA_W  newest pending data for Read_addr2
- Count  out  $clog2(DEPTH+1)  number of valid entries

## Operation
- Handshake: a request is accepted on a rising edge where In_valid && In_ready. In_ready = (Count != DEPTH). In_ready does not depend on Wr_grant, so a full buffer rejects even while draining.
- Register 0: an accepted request with In_addr == 0 is consumed and dropped. It is never enqueued and never changes Count.
- Drain: Write_En = Wr_grant && (Count != 0). Write_addr and Write_data carry the head entry when Count != 0, and are 0 otherwise. The head pops on each edge where Write_En = 1.
- Simultaneous accept and pop: both take effect on the same edge, leaving Count unchanged. Pointers wrap modulo DEPTH.
- Bypass (combinational, per port): search all valid entries, head included, and select the youngest entry whose address equals Read_addrN.
  - Read_addrN == 0 never hits.
  - On a miss, Byp_dataN = 0.
  - A request being accepted in the current cycle is not visible until the next cycle.
- Ordering: entries drain strictly in acceptance order. Multiple pending writes to the same register are all performed, oldest first.
- Reset (Reset_n == 0 at a rising edge): clears pointers and Count and discards all entries. Resulting outputs: In_ready = 1, Write_En = 0, Write_addr = 0, Write_data = 0, Byp_hit1/2 = 0, Byp_data1/2 = 0, Count = 0. Reset wins over a simultaneous accept or pop.

## Timing
- Request accepted at edge N: earliest Write_En = 1 is in cycle N+1, and the register file is updated at edge N+1.
- Bypass is valid in cycle N+1 and stays valid until the edge that pops the entry.
- Throughput: one accept and one drain per cycle.
- Write_En, Write_addr, Write_data, In_ready, Byp_* and Count are combinational from state plus Wr_grant and Read_addr*. No output is registered beyond the FIFO state.
- Combinational paths: Wr_grant -> Write_En, and Read_addr* -> Byp_*. No path from In_valid to In_ready.

## Structure
- Shared package regfile_pkg: REG_ADDR_W = 5, REG_DATA_W = 32, REG_ZERO = 5'd0. The register file and this block both use it.
- FIFO storage is a valid-bit array plus addr and data arrays, with head/tail pointers and Count.
- Sub-module wb_bypass_lookup: a youngest-first priority match over the entry array, taking the head pointer and Count. It is instantiated twice, once per read port.

## Test plan
- Reset, then accept (addr 1, 6) with Wr_grant = 1 -> next cycle Write_En = 1, Write_addr = 1, Write_data = 6, Count = 1; after the following edge Count = 0 and Write_En = 0.
- Wr_grant = 0; accept (3, 10), (3, 11), (7, 9), (2, 5) -> Count = 4, In_ready = 0. Byp on addr 3 = hit/11, addr 7 = hit/9, addr 5 = miss/0. A fifth request with In_valid = 1 is not accepted.
- Continue with Wr_grant = 1 for 4 cycles -> Write pairs (3, 10), (3, 11), (7, 9), (2, 5) in order. The addr-3 bypass stays hit/11 until the (3, 11) pop, then misses.
- Accept (0, 7) -> In_ready = 1, Count stays 0, Write_En never asserts. Read_addr1 = 0 -> Byp_hit1 = 0.
- Count = 4 and Wr_grant = 1 with In_valid = 1 -> pop only (Count = 3). Next cycle, accept plus pop -> Count stays 3. Pointers wrap past DEPTH-1 without data corruption.
- Count = 3, then Reset_n = 0 for one edge while In_valid = 1 and Wr_grant = 1 -> Count = 0, all outputs at reset values, no Write_En pulse afterward.
